piso_shift_tx: RTL
==================

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter: WIDTH, default 4, word length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clear_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: p_in  input  WIDTH  parallel word to transmit.
REQ-005 Port: load_valid  input  1  p_in holds a word to transmit.
REQ-006 Port: load_ready  output  1  block can accept a word this cycle.
REQ-007 Port: s_out  output  1  serial data, LSB first.
REQ-008 Port: s_valid  output  1  s_out carries a valid data bit.
REQ-009 Port: busy  output  1  a word is being shifted out.
REQ-010 Port: done  output  1  one-cycle pulse coincident with the last bit of a word.

Function
REQ-011 The block SHALL contain a two-state FSM: IDLE (no word in flight) and SHIFT (word in flight).
REQ-012 The block SHALL hold a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits, counting 0..WIDTH-1.
REQ-013 The block SHALL drive load_ready combinationally: 1 in IDLE; 1 in SHIFT only when counter = WIDTH-1; 0 while clear_n is low.
REQ-014 A word SHALL be accepted only at a rising edge where load_valid=1 and load_ready=1; p_in is sampled at that edge only, and later changes to p_in SHALL be ignored.
REQ-015 On acceptance, the block SHALL load the shift register from p_in, clear the counter, enter SHIFT, and in the following cycle drive s_out=p_in[0], s_valid=1, busy=1.
REQ-016 At each edge in SHIFT with counter < WIDTH-1, the block SHALL shift the register right by one, increment the counter, and drive s_out with the next bit; after i edges, s_out = word[i].
REQ-017 s_out, s_valid, busy and done SHALL be registered outputs with no combinational path from inputs.
REQ-018 done SHALL be 1 exactly during the cycle in which s_out = word[WIDTH-1], and 0 otherwise.
REQ-019 At the edge ending the last-bit cycle: if a new word is accepted, the block SHALL stay in SHIFT and present the new word[0] in the next cycle with no gap, keeping s_valid=1; otherwise it SHALL enter IDLE with s_out=0, s_valid=0, busy=0.
REQ-020 load_valid asserted in SHIFT with counter < WIDTH-1 SHALL be ignored and SHALL NOT disturb the word in flight.
REQ-021 Each accepted word SHALL produce exactly WIDTH consecutive cycles with s_valid=1 and exactly one done pulse.
REQ-022 In IDLE, s_out SHALL be 0.

Reset
REQ-023 While clear_n=0, the block SHALL immediately force state=IDLE, shift register=0, counter=0, s_out=0, s_valid=0, busy=0, done=0 and load_ready=0, regardless of clk.
REQ-024 A reset during SHIFT SHALL abort the word with no done pulse; after release, the next accepted word SHALL start from bit 0.
REQ-025 On the first rising edge after clear_n deasserts, the block SHALL be able to accept a word (load_ready=1).

Verification
REQ-026 Reset: clear_n=0 mid-cycle -> all outputs 0 and load_ready=0 without a clock edge; release -> load_ready=1.
REQ-027 Single word, WIDTH=4: load 4'b1011 -> s_out 1,1,0,1 on 4 consecutive cycles, s_valid=1 for exactly those 4 cycles, done only on the 4th, then IDLE with s_valid=0.
REQ-028 Back-to-back: load_valid held high with 4'hA, then 4'h5 -> 8 contiguous bits 0,1,0,1,1,0,1,0; s_valid never drops; done on bits 4 and 8.
REQ-029 Load while busy: load_valid=1 with p_in=4'hF during bit 1 of 4'h3 -> not accepted; stream stays 1,1,0,0.
REQ-030 Reset mid-word: clear_n pulsed low during bit 2 of 4'h9 -> outputs 0 at once, no done; next load 4'h6 -> stream 0,1,1,0.
REQ-031 Loopback: s_out feeds the team's 4-bit SISO shift register (shifts in at bit 3 toward bit 0) on the same clk -> after 4 bits, its parallel output equals the loaded word for 4'h1, 4'h8, 4'hC and 4'hE.

Source files
------------

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out transmitter with a valid/ready load port.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   clear_n    : asynchronous active-low reset
//   p_in       : WIDTH-bit word to transmit
//   load_valid : p_in holds a word to transmit
//   load_ready : a word can be accepted this cycle (combinational)
//   s_out      : serial data, LSB first (registered)
//   s_valid    : s_out carries a valid data bit (registered)
//   busy       : a word is being shifted out (registered)
//   done       : one-cycle pulse coincident with the last bit of a word (registered)
module piso_shift_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_out_q, s_out_d;
  logic             s_valid_q, s_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;

  // The counter sits at CNT_LAST during the cycle the final bit is on s_out;
  // accepting then lets the next word follow with no idle gap.
  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    load_ready = clear_n && ((state_q == IDLE) || last_bit);
    accept     = load_valid && load_ready;
  end

  // State register (holds the whole datapath as well)
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (last_bit && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values. s_out_d is taken one bit
  // ahead of the register so s_out is itself a flop, not a tap of shreg_q.
  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    s_out_d   = 1'b0;
    s_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (accept) begin
      shreg_d   = p_in;
      cnt_d     = '0;
      s_out_d   = p_in[0];
      s_valid_d = 1'b1;
      busy_d    = 1'b1;
      done_d    = (CNT_LAST == '0);
    end else if (state_q == SHIFT && !last_bit) begin
      shreg_d   = shreg_q >> 1;
      cnt_d     = cnt_q + CW'(1);
      s_out_d   = shreg_q[1];
      s_valid_d = 1'b1;
      busy_d    = 1'b1;
      done_d    = (cnt_d == CNT_LAST);
    end else if (state_q == SHIFT) begin
      shreg_d = '0;
      cnt_d   = '0;
    end
  end

  assign s_out   = s_out_q;
  assign s_valid = s_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
